// File: rtl/kalyna_round_engine.sv
// kalyna_round_engine: iterative Kalyna-style 128-bit block encryptor, one round per clock.
// A single SBOX/SR/MC datapath serves every round, with a second copy for the key schedule.
// Valid/ready handshakes on the message/key side and on the cipher side.
// Optional build macro KALYNA_ROUND_TAP_EN adds the debug ports dbg_state and dbg_round.
//
// Round primitives used by this engine:
//   sbox lane t (0..3): hi = P[t][x_hi]; lo = P[(t+1)%4][x_lo ^ hi]; result {hi, lo}
//     P[0..3] = PRESENT, GIFT, Midori Sb0 and Piccolo 4-bit permutations.
//   SR: the state is two 8-byte columns (bytes 0-7 and 8-15, MSB first); rows 4..7 swap columns.
//   MC: per column, out[row] = XOR_j MDS[(j-row) mod 8] * in[j] over GF(2^8), poly 0x11D.
//   interkey(k) = MC(SR(SBOX(k ^ {16{8'h5A}}))).
module kalyna_round_engine #(
  parameter int unsigned NUM_ROUNDS = 10,
  parameter int unsigned ROT_AMT    = 56,
  parameter int unsigned MOD_BIT    = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] msg,
  input  logic [127:0] key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] cipher
`ifdef KALYNA_ROUND_TAP_EN
  ,
  output logic [127:0] dbg_state,
  output logic [$clog2(NUM_ROUNDS+1)-1:0] dbg_round
`endif
);

  localparam int unsigned CNT_W = $clog2(NUM_ROUNDS + 1);

  localparam logic [255:0] NIB_TAB =
    256'hC56B90AD3EF84712_1A4C6F392DB7508E_CAD3EBF789150246_E4B238091A7F6C5D;
  localparam logic [127:0] KCONST = {16{8'h5A}};
  localparam logic [127:0] WMOD   = 128'd1 << MOD_BIT;
  localparam logic [7:0]   MDS [8] = '{8'h01, 8'h01, 8'h05, 8'h01, 8'h08, 8'h06, 8'h07, 8'h04};

  typedef logic [15:0][7:0] bytes_t;  // element 15 is the most significant byte

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } fsm_t;

  // 4-bit permutation t applied to nibble x
  function automatic logic [3:0] nib(input logic [1:0] t, input logic [3:0] x);
    logic [255:0] sh;
    sh = NIB_TAB << {t, x, 2'b00};
    return sh[255:252];
  endfunction

  // Byte substitution for lane t
  function automatic logic [7:0] sbox_byte(input logic [1:0] t, input logic [7:0] x);
    logic [3:0] hi;
    logic [3:0] lo;
    hi = nib(t, x[7:4]);
    lo = nib(t + 2'd1, x[3:0] ^ hi);
    return {hi, lo};
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    bytes_t b;
    bytes_t r;
    b = s;
    for (int i = 0; i < 16; i++) begin
      r[15-i] = sbox_byte(2'(i), b[15-i]);
    end
    return r;
  endfunction

  // Rows 4..7 trade places between the two columns
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    bytes_t b;
    bytes_t r;
    b = s;
    for (int i = 0; i < 16; i++) begin
      r[15-i] = ((i % 8) >= 4) ? b[15-(i^8)] : b[15-i];
    end
    return r;
  endfunction

  // GF(2^8) multiply, reduction polynomial x^8+x^4+x^3+x^2+1
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1D : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    bytes_t b;
    bytes_t r;
    logic [7:0] acc;
    b = s;
    for (int c = 0; c < 2; c++) begin
      for (int row = 0; row < 8; row++) begin
        acc = 8'h00;
        for (int j = 0; j < 8; j++) begin
          acc = acc ^ gmul(MDS[3'(j - row)], b[15-(8*c+j)]);
        end
        r[15-(8*c+row)] = acc;
      end
    end
    return r;
  endfunction

  function automatic logic [127:0] round_fn(input logic [127:0] s);
    return mix_columns(shift_rows(sub_bytes(s)));
  endfunction

  function automatic logic [127:0] interkey(input logic [127:0] k);
    return round_fn(k ^ KCONST);
  endfunction

  // Modular whitening add; s == 2**MOD_BIT passes unchanged
  function automatic logic [127:0] wadd(input logic [127:0] a, input logic [127:0] b);
    logic [127:0] s;
    s = a + b;
    if (s > WMOD) s = s - WMOD;
    return s;
  endfunction

  fsm_t             fsm_q;
  fsm_t             fsm_d;
  logic [CNT_W-1:0] rnd_q;
  logic [127:0]     state_q;
  logic [127:0]     kreg_q;
  logic [127:0]     round_out;
  logic [127:0]     key_next;
  logic [127:0]     key_first;
  logic             last_round;

  // Round datapath and key schedule for the current cycle
  always_comb begin
    round_out  = round_fn(state_q);
    key_next   = interkey(kreg_q);
    key_first  = interkey(key);
    last_round = (rnd_q == CNT_W'(NUM_ROUNDS));
  end

  // Next-state logic
  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      S_IDLE:  if (in_valid) fsm_d = S_RUN;
      S_RUN:   if (last_round) fsm_d = S_DONE;
      S_DONE:  if (out_ready) fsm_d = S_IDLE;
      default: fsm_d = S_IDLE;
    endcase
  end

  // State register and registered handshake flags
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q     <= S_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      fsm_q     <= fsm_d;
      in_ready  <= (fsm_d == S_IDLE);
      out_valid <= (fsm_d == S_DONE);
    end
  end

  // Block state, round key, round counter and cipher registers
  always_ff @(posedge clk) begin
    if (rst) begin
      rnd_q   <= '0;
      state_q <= '0;
      kreg_q  <= '0;
      cipher  <= '0;
    end else begin
      case (fsm_q)
        S_IDLE: begin
          if (in_valid) begin
            kreg_q  <= key_first;
            state_q <= wadd(msg, key_first);
            rnd_q   <= CNT_W'(1);
          end
        end
        S_RUN: begin
          if (last_round) begin
            cipher <= wadd(round_out, kreg_q);
          end else begin
            state_q <= rnd_q[0] ? ((kreg_q << ROT_AMT) ^ round_out) : (key_next ^ round_out);
            kreg_q  <= key_next;
            rnd_q   <= rnd_q + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef KALYNA_ROUND_TAP_EN
  assign dbg_state = state_q;
  assign dbg_round = rnd_q;
`endif

endmodule
